// File: rtl/mc_controller_if.sv
// mc_controller_if
//   Bundles the signals between the multicycle control unit and the datapath.
//   The instruction fields and Zero flow into the controller. Every mux select,
//   write enable and the debug state flow out of it.
//   master : controller side (consumes instruction fields, drives controls)
//   slave  : datapath side (drives instruction fields, consumes controls)
//   Signals:
//     op[6:0], funct3[2:0], funct7b5, Zero        instruction fields / ALU flag
//     ImmSrc[2:0]                                 immediate extender select
//     PCWrite, AdrSrc, MemWrite, IRWrite          PC / memory / IR controls
//     ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0]  datapath mux selects
//     ALUControl[2:0], RegWrite                   ALU op, register file write
//     IllegalInstr                                unsupported opcode pulse
//     state[STATE_W-1:0]                          current controller state (debug)
interface mc_controller_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               Zero;
  logic [2:0]         ImmSrc;
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [2:0]         ALUControl;
  logic               RegWrite;
  logic               IllegalInstr;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output ImmSrc, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, RegWrite, IllegalInstr, state
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  ImmSrc, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, RegWrite, IllegalInstr, state
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller
//   Multicycle main control unit for an RV32I core. It steps each instruction
//   through fetch, decode, execute, memory and writeback, sharing one ALU, one
//   memory port and one immediate extender.
//   Ports:
//     clk    : clock, rising edge
//     reset  : synchronous, active-high; the next state is FETCH
//     bus    : mc_controller_if.master (instruction fields in, controls out)
//   Optional feature, macro MC_UPPER_IMM_EN:
//     defined   - lui/auipc execute via the UPPER state, ImmSrc 100
//     undefined - lui/auipc are illegal opcodes, ImmSrc 000
module mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
`ifdef MC_UPPER_IMM_EN
    S_JAL      = 4'd10,
    S_UPPER    = 4'd11
`else
    S_JAL      = 4'd10
`endif
  } state_t;

  state_t     state_q, state_d;
  state_t     cur;
  logic       pc_update, branch, taken;
  logic       adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src, alu_ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Outputs are decoded as if in FETCH while reset is high, so the datapath
  // sees the FETCH selects and the enables are forced low further down.
  always_comb begin
    state_d    = state_q;
    cur        = reset ? S_FETCH : state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (cur)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target OldPC + imm
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
`ifdef MC_UPPER_IMM_EN
          7'b0110111, 7'b0010111: state_d = S_UPPER;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // ALU forms the link address OldPC + 4 while PC takes the target
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
`ifdef MC_UPPER_IMM_EN
      S_UPPER: begin
        // lui adds the immediate to zero, auipc adds it to OldPC
        alu_src_a = bus.op[5] ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_comb begin
    case (bus.op)
      7'b0100011: imm_src = 3'b001;
      7'b1100011: imm_src = 3'b010;
      7'b1101111: imm_src = 3'b011;
`ifdef MC_UPPER_IMM_EN
      7'b0110111, 7'b0010111: imm_src = 3'b100;
`endif
      default:    imm_src = 3'b000;
    endcase
  end

  always_comb begin
    case (alu_op)
      2'b00: alu_ctrl = 3'b000;
      2'b01: alu_ctrl = 3'b001;
      default: begin
        case (bus.funct3)
          // Only R-type (op[5]=1) uses funct7b5 to select sub
          3'b000:  alu_ctrl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl = 3'b101;
          3'b110:  alu_ctrl = 3'b011;
          3'b111:  alu_ctrl = 3'b010;
          default: alu_ctrl = 3'b000;
        endcase
      end
    endcase
  end

  // beq branches on Zero, bne on !Zero
  assign taken = bus.Zero ^ bus.funct3[0];

  assign bus.ImmSrc       = imm_src;
  assign bus.PCWrite      = pc_update | (branch & taken);
  assign bus.AdrSrc       = adr_src;
  assign bus.MemWrite     = mem_write;
  assign bus.IRWrite      = ir_write;
  assign bus.ResultSrc    = result_src;
  assign bus.ALUSrcA      = alu_src_a;
  assign bus.ALUSrcB      = alu_src_b;
  assign bus.ALUControl   = alu_ctrl;
  assign bus.RegWrite     = reg_write;
  assign bus.IllegalInstr = illegal;
  assign bus.state        = STATE_W'(state_q);

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle main control unit for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback over several cycles, using one shared ALU, one unified memory port and one immediate extender.
- Drives the extender's 3-bit ImmSrc select plus every datapath mux and write-enable.
- Sits beside the datapath and consumes only instruction fields and the ALU Zero flag.

Parameters:
- STATE_W, 4, width of state register and debug state output.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU result == 0
- ImmSrc  out  3  extender select: 000 I, 001 S, 010 B, 011 J, 100 U
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 PC, 1 Result
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction/OldPC register enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  out  1  register file write enable
- IllegalInstr  out  1  one-cycle pulse on unsupported opcode
- state  out  STATE_W  current state, for debug

Behaviour:
- Single clk domain. Reset is synchronous, active-high: state <= FETCH at the next edge.
- While reset is high, PCWrite, MemWrite, IRWrite, RegWrite and IllegalInstr are forced to 0. All other outputs take their FETCH values.
- Datapath outputs are Moore functions of state. The exceptions are:
  - ImmSrc, decoded from op.
  - ALUControl, decoded from ALUOp, funct3, funct7b5 and op[5].
  - PCWrite = PCUpdate | (Branch & taken), with taken = Zero ^ funct3[0] (beq/bne).
- ImmSrc by op:
  - 0000011, 0010011, 1100111 -> 000
  - 0100011 -> 001
  - 1100011 -> 010
  - 1101111 -> 011
  - 0110111, 0010111 -> 100
  - any other op -> 000
- ALUOp encoding: 00 add, 01 sub, 10 funct decode.
- ALUOp 10 decode:
  - funct3 000 -> sub if (op[5] & funct7b5), else add
  - 010 -> slt
  - 110 -> or
  - 111 -> and
  - any other -> 000
- States and per-state outputs (unlisted enables 0):
  - FETCH(0): AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10, PCUpdate 1 -> DECODE.
  - DECODE(1): ALUSrcA 01, ALUSrcB 01, ALUOp 00 (branch target precompute). Next state by op:
    - lw/sw -> MEMADR
    - R -> EXECR
    - I-ALU -> EXECI
    - beq/bne -> BRANCH
    - jal -> JAL
    - U-type -> UPPER (see optional feature)
    - otherwise IllegalInstr = 1 and -> FETCH
  - MEMADR(2): ALUSrcA 10, ALUSrcB 01, ALUOp 00 -> MEMREAD if op[5] = 0, else MEMWRITE.
  - MEMREAD(3): ResultSrc 00, AdrSrc 1 -> MEMWB.
  - MEMWB(4): ResultSrc 01, RegWrite 1 -> FETCH.
  - MEMWRITE(5): ResultSrc 00, AdrSrc 1, MemWrite 1 -> FETCH.
  - EXECR(6): ALUSrcA 10, ALUSrcB 00, ALUOp 10 -> ALUWB.
  - EXECI(7): ALUSrcA 10, ALUSrcB 01, ALUOp 10 -> ALUWB.
  - ALUWB(8): ResultSrc 00, RegWrite 1 -> FETCH.
  - BRANCH(9): ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1 -> FETCH.
  - JAL(10): ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1 -> ALUWB.
  - UPPER(11): ALUSrcB 01, ALUOp 00; ALUSrcA 11 for lui, 01 for auipc -> ALUWB.
  - Unused encodings 12-15 -> FETCH with all enables 0.
- Latency in cycles: lw 5, sw 4, R 4, I-ALU 4, branch 3, jal 4, lui/auipc 4, illegal 2.
- Reset asserted in any state aborts the instruction. No write enable is asserted in that cycle; FETCH follows.

Optional Feature:
- Macro: MC_UPPER_IMM_EN.
- Defined: lui (0110111) and auipc (0010111) route DECODE -> UPPER -> ALUWB, and ImmSrc = 100 for these opcodes.
- Undefined: UPPER state is absent and encoding 11 is unused. Both opcodes are illegal: IllegalInstr pulses in DECODE and the next state is FETCH. ImmSrc for them is 000.

Test Plan:
- Reset high 2 cycles then low -> state 0, PCWrite 0 during reset; first post-reset cycle IRWrite 1, PCWrite 1, ALUSrcB 10.
- op 0000011 (lw) -> states 0,1,2,3,4,0; RegWrite 1 only in state 4 with ResultSrc 01; ImmSrc 000 throughout.
- op 1100011, funct3 001 (bne), Zero 0 -> states 0,1,9; PCWrite 1 in state 9, ALUControl 001, ImmSrc 010. Repeat with Zero 1 -> PCWrite 0 in state 9.
- op 0110011, funct3 000, funct7b5 1 -> ALUControl 001 in state 6. op 0010011, funct3 000, funct7b5 1 -> ALUControl 000 (addi, not sub).
- op 0110111: with MC_UPPER_IMM_EN -> states 0,1,11,8; ALUSrcA 11, ImmSrc 100. Without it -> IllegalInstr 1 in state 1, next state 0.
- Assert reset while in state 5 (sw) -> MemWrite 0 that cycle; state 0 next cycle.
